regfile_wport_ctrl: RTL and testbench

Write-port controller and read-select decoder for the 32x32 register file. It shares the file's single write port between two writeback requesters, port 0 (ALU) and port 1 (load/memory), using valid/ready handshakes, a one-entry holding register per port, and a registered output stage. It also decodes the two 5-bit read addresses into the one-hot A/B bus selects, and flags read-after-write hazards against writes that are still pending. It sits between the pipeline writeback stage and the register-file cells; those cells capture data on the falling edge of `clk`.

---
 rtl/regfile_wport_ctrl.sv | 147 ++++++++++++++
 tb/tb_regfile_wport_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wport_ctrl.sv
// ---------------------------------------------------------------------------
// regfile_wport_ctrl
//
// Shares the register file's single write port between two writeback
// requesters (port 0 = ALU, port 1 = load/memory). Each port has a one-entry
// holding register behind a valid/ready handshake. An arbiter picks one
// holder per cycle and moves it into a registered output stage that drives
// the one-hot write enable (Dselect) and write data (D) to the register
// cells. The cells capture on the falling edge of clk. The block also decodes
// the two read addresses to one-hot selects and flags read-after-write
// hazards against writes that are still held or staged.
//
// Configuration macro:
//   RFCTRL_RR_EN  defined   : round-robin arbitration on two-way contention
//                 undefined : fixed priority, port 0 always wins
//
// Parameters:
//   NREG  number of registers / one-hot select width
//   AW    register address width
//   DW    data width
//
// Ports:
//   clk, reset            clock (posedge state update), async active-high reset
//   wr0_valid/ready/addr/data   port 0 write handshake, address and data
//   wr1_valid/ready/addr/data   port 1 write handshake, address and data
//   Dselect, D            one-hot write enable and write data to the cells
//   Aaddr, Baddr          read addresses
//   Aselect, Bselect      one-hot read selects (combinational)
//   hazard                nonzero read address matches a pending write
// ---------------------------------------------------------------------------
module regfile_wport_ctrl #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr0_valid,
    output logic            wr0_ready,
    input  logic [AW-1:0]   wr0_addr,
    input  logic [DW-1:0]   wr0_data,
    input  logic            wr1_valid,
    output logic            wr1_ready,
    input  logic [AW-1:0]   wr1_addr,
    input  logic [DW-1:0]   wr1_data,
    output logic [NREG-1:0] Dselect,
    output logic [DW-1:0]   D,
    input  logic [AW-1:0]   Aaddr,
    input  logic [AW-1:0]   Baddr,
    output logic [NREG-1:0] Aselect,
    output logic [NREG-1:0] Bselect,
    output logic            hazard
);

    logic          r_held0, r_held1, r_svalid;
    logic [AW-1:0] r_haddr0, r_haddr1, r_saddr;
    logic [DW-1:0] r_hdata0, r_hdata1, r_sdata;

    logic w_prio0;
    logic w_grant0, w_grant1;

    // w_prio0 decides the winner only when both holders are valid.
`ifdef RFCTRL_RR_EN
    logic r_prio1;  // 1: port 1 wins the next two-way contention

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prio1 <= 1'b0;
        end else if (r_held0 && r_held1) begin
            // Whoever wins now loses the next contention.
            r_prio1 <= w_grant0;
        end
    end

    assign w_prio0 = !r_prio1;
`else
    assign w_prio0 = 1'b1;
`endif

    assign w_grant0 = r_held0 && (!r_held1 || w_prio0);
    assign w_grant1 = r_held1 && (!r_held0 || !w_prio0);

    // A draining holder can be refilled on the same edge.
    assign wr0_ready = !reset && (!r_held0 || w_grant0);
    assign wr1_ready = !reset && (!r_held1 || w_grant1);

    // ---- holding registers and output stage ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_held0  <= 1'b0;
            r_haddr0 <= '0;
            r_hdata0 <= '0;
            r_held1  <= 1'b0;
            r_haddr1 <= '0;
            r_hdata1 <= '0;
            r_svalid <= 1'b0;
            r_saddr  <= '0;
            r_sdata  <= '0;
        end else begin
            if (wr0_valid && wr0_ready) begin
                r_held0  <= 1'b1;
                r_haddr0 <= wr0_addr;
                r_hdata0 <= wr0_data;
            end else if (w_grant0) begin
                r_held0 <= 1'b0;
            end

            if (wr1_valid && wr1_ready) begin
                r_held1  <= 1'b1;
                r_haddr1 <= wr1_addr;
                r_hdata1 <= wr1_data;
            end else if (w_grant1) begin
                r_held1 <= 1'b0;
            end

            if (w_grant0) begin
                r_svalid <= 1'b1;
                r_saddr  <= r_haddr0;
                r_sdata  <= r_hdata0;
            end else if (w_grant1) begin
                r_svalid <= 1'b1;
                r_saddr  <= r_haddr1;
                r_sdata  <= r_hdata1;
            end else begin
                r_svalid <= 1'b0;
            end
        end
    end

    // ---- cell-side outputs, from stage registers only ----
    // r0 is hardwired: a staged write to it is consumed but never enabled.
    assign Dselect = (r_svalid && (r_saddr != '0)) ? (NREG'(1) << r_saddr) : '0;
    assign D       = r_sdata;

    assign Aselect = NREG'(1) << Aaddr;
    assign Bselect = NREG'(1) << Baddr;

    function automatic logic pending_hit(input logic [AW-1:0] addr);
        return (addr != '0) &&
               ((r_held0  && (addr == r_haddr0)) ||
                (r_held1  && (addr == r_haddr1)) ||
                (r_svalid && (addr == r_saddr)));
    endfunction

    assign hazard = pending_hit(Aaddr) || pending_hit(Baddr);

endmodule

// File: tb/tb_regfile_wport_ctrl.sv
module tb_regfile_wport_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr0_valid, wr1_valid;
    logic        wr0_ready, wr1_ready;
    logic [4:0]  wr0_addr, wr1_addr;
    logic [31:0] wr0_data, wr1_data;
    logic [31:0] Dselect, D;
    logic [4:0]  Aaddr, Baddr;
    logic [31:0] Aselect, Bselect;
    logic        hazard;

    regfile_wport_ctrl #(.NREG(32), .AW(5), .DW(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr0_valid (wr0_valid),
        .wr0_ready (wr0_ready),
        .wr0_addr  (wr0_addr),
        .wr0_data  (wr0_data),
        .wr1_valid (wr1_valid),
        .wr1_ready (wr1_ready),
        .wr1_addr  (wr1_addr),
        .wr1_data  (wr1_data),
        .Dselect   (Dselect),
        .D         (D),
        .Aaddr     (Aaddr),
        .Baddr     (Baddr),
        .Aselect   (Aselect),
        .Bselect   (Bselect),
        .hazard    (hazard)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int          cyc;
        logic [31:0] dsel;
        logic [31:0] d;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input int c, input logic [31:0] dsel, input logic [31:0] d);
        exp_t e;
        e.cyc  = c;
        e.dsel = dsel;
        e.d    = d;
        q.push_back(e);
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        wr0_valid = 1'b0;
        wr1_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    // Monitor: every cycle, either the scheduled write is on the bus or the bus is idle.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            chk("Dselect", Dselect, e.dsel);
            chk("D", D, e.d);
        end else begin
            chk("Dselect_idle", Dselect, 32'h0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        reset     = 1'b1;
        wr0_valid = 1'b0; wr0_addr = '0; wr0_data = '0;
        wr1_valid = 1'b0; wr1_addr = '0; wr1_data = '0;
        Aaddr     = 5'd4;
        Baddr     = 5'd0;
        step();
        step();
        reset = 1'b0;
        step();

        // ---- reset mid-write: staged write dropped before its negedge ----
        wr0_valid = 1'b1; wr0_addr = 5'd5; wr0_data = 32'hAAAA_5555;
        step();
        wr0_valid = 1'b0;
        step();                  // write is now in the output stage
        #1 reset = 1'b1;         // before the negedge
        #1;
        chk("rst_Dselect", Dselect, 32'h0);
        chk("rst_D", D, 32'h0);
        chk("rst_wr0_ready", 32'(wr0_ready), 32'h0);
        chk("rst_wr1_ready", 32'(wr1_ready), 32'h0);
        chk("rst_Aselect", Aselect, 32'h0000_0010);
        chk("rst_hazard", 32'(hazard), 32'h0);
        step();
        reset = 1'b0;
        Aaddr = 5'd0;
        @(negedge clk);
        chk("post_rst_wr0_ready", 32'(wr0_ready), 32'h1);
        chk("post_rst_wr1_ready", 32'(wr1_ready), 32'h1);
        step();

        // ---- single write ----
        wr0_valid = 1'b1; wr0_addr = 5'd5; wr0_data = 32'hDEAD_BEEF;
        push(cyc + 2, 32'h0000_0020, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("single_ready", 32'(wr0_ready), 32'h1);
        step();
        idle(4);

        // ---- first contention: port 0 wins in both arbitration modes ----
        t = cyc;
        wr0_valid = 1'b1; wr0_addr = 5'd3; wr0_data = 32'h1111_1111;
        wr1_valid = 1'b1; wr1_addr = 5'd7; wr1_data = 32'h2222_2222;
        push(t + 2, 32'h0000_0008, 32'h1111_1111);
        push(t + 3, 32'h0000_0080, 32'h2222_2222);
        step();
        wr0_valid = 1'b0; wr1_valid = 1'b0;
        @(negedge clk);          // both held: port 1 waits
        chk("cont1_wr1_ready", 32'(wr1_ready), 32'h0);
        chk("cont1_wr0_ready", 32'(wr0_ready), 32'h1);
        step();
        idle(4);

        // ---- repeat contention ----
        t = cyc;
        wr0_valid = 1'b1; wr0_addr = 5'd10; wr0_data = 32'h3333_3333;
        wr1_valid = 1'b1; wr1_addr = 5'd11; wr1_data = 32'h4444_4444;
`ifdef RFCTRL_RR_EN
        push(t + 2, 32'h0000_0800, 32'h4444_4444);
        push(t + 3, 32'h0000_0400, 32'h3333_3333);
`else
        push(t + 2, 32'h0000_0400, 32'h3333_3333);
        push(t + 3, 32'h0000_0800, 32'h4444_4444);
`endif
        step();
        wr0_valid = 1'b0; wr1_valid = 1'b0;
        @(negedge clk);
`ifdef RFCTRL_RR_EN
        chk("cont2_wr0_ready", 32'(wr0_ready), 32'h0);
        chk("cont2_wr1_ready", 32'(wr1_ready), 32'h1);
`else
        chk("cont2_wr0_ready", 32'(wr0_ready), 32'h1);
        chk("cont2_wr1_ready", 32'(wr1_ready), 32'h0);
`endif
        step();
        idle(4);

        // ---- write to r0: data reaches D, no enable ----
        wr0_valid = 1'b1; wr0_addr = 5'd0; wr0_data = 32'hFFFF_FFFF;
        push(cyc + 2, 32'h0, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("r0_ready", 32'(wr0_ready), 32'h1);
        step();
        idle(4);

        // ---- hazard tracking on port 1 ----
        wr1_valid = 1'b1; wr1_addr = 5'd9; wr1_data = 32'h9999_0009;
        push(cyc + 2, 32'h0000_0200, 32'h9999_0009);
        step();
        wr1_valid = 1'b0;
        Baddr = 5'd9;            // entry held
        #1;
        chk("hz_held", 32'(hazard), 32'h1);
        chk("hz_Bselect", Bselect, 32'h0000_0200);
        chk("hz_Aselect", Aselect, 32'h0000_0001);
        step();                  // entry staged
        chk("hz_staged", 32'(hazard), 32'h1);
        Baddr = 5'd0;
        #1;
        chk("hz_r0", 32'(hazard), 32'h0);
        Baddr = 5'd9;
        step();                  // entry has left the stage
        chk("hz_retired", 32'(hazard), 32'h0);
        Baddr = 5'd0;
        idle(3);

        // ---- throughput: 8 back-to-back writes on port 0 ----
        for (int i = 0; i < 8; i++) begin
            wr0_valid = 1'b1;
            wr0_addr  = 5'(i + 1);
            wr0_data  = 32'h0000_0100 + 32'(i);
            push(cyc + 2, 32'h1 << (i + 1), 32'h0000_0100 + 32'(i));
            @(negedge clk);
            chk("tput_ready", 32'(wr0_ready), 32'h1);
            step();
        end
        idle(5);

        chk("scoreboard_drained", 32'(q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
